cnt_cycle_sched: RTL and testbench
==================================

Name: cnt_cycle_sched

Overview:
Schedules counter-increment cycles into the memory-cycle stream generated by the timer. It does this by replacing instruction cycles at T12 boundaries with counter cycles.
- N_CH external channels each raise up or down count requests. The block latches them as pending and picks the lowest-numbered pending channel at each end-of-memory-cycle strobe.
- While a counter cycle is active it drives the channel index and direction to the counter datapath.
- GOJAM clears all scheduler state.

Parameters:
N_CH, 20, number of counter channels (1..32)
CH_W, 5, width of channel index, ceil(log2(N_CH)) minimum 1
MAX_BURST, 4, maximum consecutive counter cycles before one instruction cycle is forced (1..15)

Ports:
SIM_CLK  input  1  simulation clock; all state changes on rising edge
SIM_RST  input  1  reset, asynchronous, active-low
T12_STB  input  1  one-SIM_CLK pulse marking end of memory cycle (T12 to T01 boundary)
GOJAM  input  1  synchronous clear, high-active
INKL  input  1  inhibit counter cycles (sampled only at T12_STB)
REQ_UP  input  N_CH  per-channel up-count request, level, rising edge significant
REQ_DN  input  N_CH  per-channel down-count request, level, rising edge significant
CNT_CYC  output  1  current memory cycle is a counter cycle
CNT_CH  output  CH_W  channel being serviced (valid while CNT_CYC)
PINC  output  1  CNT_CYC and direction up
MINC  output  1  CNT_CYC and direction down
GRANT_STB  output  1  one-cycle pulse on each new grant
PEND  output  N_CH  pending bits
LOST  output  1  sticky: a same-direction request arrived while that channel was already pending

Behaviour:
- Reset (SIM_RST=0): all flops cleared asynchronously.
  - State IDLE; PEND=0, dir=0, edge regs=0, LOST=0.
  - CNT_CYC=0, CNT_CH=0, PINC=MINC=0, GRANT_STB=0, burst=0.
- Edge detect:
  - Registered previous REQ_UP/REQ_DN.
  - up_ev[i] = REQ_UP[i] & ~prev_up[i]; dn_ev likewise.
  - An event at cycle k affects PEND at edge k+1.
- Per-channel pending update, in priority order:
  1. GOJAM → PEND=0.
  2. up_ev & dn_ev together → no change to PEND/dir.
  3. Channel not pending and one event → PEND=1, dir=event direction.
  4. Channel pending with the same direction → PEND unchanged, LOST=1.
  5. Channel pending with the opposite direction → PEND=0 (net zero).
  6. Grant clears the bit unless an event for that channel arrives in the same cycle; that event is then applied as if the bit were 0.
- Arbitration:
  - Evaluated only in cycles where T12_STB=1 and GOJAM=0.
  - Uses the registered PEND value, so an event in the T12_STB cycle misses that arbitration.
  - Winner is the lowest index i with PEND[i]=1.
- FSM, states IDLE and CNT:
  - IDLE, T12_STB, INKL=0, PEND≠0 → CNT. Latch CNT_CH=winner and its dir; clear its PEND; burst=1; GRANT_STB=1 next cycle.
  - IDLE, T12_STB, otherwise → stay IDLE; burst=0.
  - CNT, T12_STB, INKL=0, PEND≠0, burst<MAX_BURST → stay CNT with a new grant; burst+1; GRANT_STB pulse.
  - CNT, T12_STB, otherwise → IDLE; CNT_CYC=0.
  - The forced instruction cycle resets burst, so the next eligible T12_STB may grant again.
- Outputs:
  - CNT_CYC=(state==CNT); PINC/MINC registered, mutually exclusive.
  - CNT_CH holds its last value while in IDLE.
- GOJAM (sync):
  - Next edge → IDLE, PEND=0, LOST=0, burst=0, CNT_CYC=0.
  - Overrides T12_STB in the same cycle.
  - Edge regs still track REQ, so a level held through GOJAM does not re-fire.
- Channels ≥ N_CH do not exist. CNT_CH never exceeds N_CH-1.

Test Plan:
- Reset then idle: SIM_RST low 3 cycles with REQ_UP[3] high → PEND=0, LOST=0. After release with REQ_UP[3] still high → no event (prev_up=1 only after the first clock; allowed single event at first clock). Document and check PEND[3]=1 after 1 cycle.
- Single up request: pulse REQ_UP[5], then T12_STB → next cycle CNT_CYC=1, CNT_CH=5, PINC=1, GRANT_STB=1, PEND[5]=0. Next T12_STB → CNT_CYC=0.
- Priority and burst (MAX_BURST=4): pend channels 2, 7, 9, 12, 15 via REQ_DN, then 6 T12_STB → grants 2, 7, 9, 12 (MINC), then one IDLE cycle, then 15.
- Cancel and LOST: REQ_UP[4] pulse then REQ_DN[4] pulse → PEND[4]=0, LOST=0. REQ_UP[8] twice → PEND[8]=1, LOST=1.
- INKL and simultaneity: PEND[1]=1, INKL=1 at T12_STB → stays IDLE. REQ_UP[0] rising in the same cycle as a T12_STB with INKL=0 → channel 1 granted, channel 0 granted at the following T12_STB.
- GOJAM mid-burst: in CNT with 3 pending, GOJAM with T12_STB → IDLE, PEND=0, LOST=0; no GRANT_STB.

Source files
------------

// File: rtl/cnt_cycle_sched.sv
// rtl/cnt_cycle_sched.sv - counter-cycle scheduler that steals memory cycles at T12 boundaries
module cnt_cycle_sched #(
  parameter int N_CH      = 20,
  parameter int CH_W      = 5,
  parameter int MAX_BURST = 4
) (
  input  logic            SIM_CLK,
  input  logic            SIM_RST,
  input  logic            T12_STB,
  input  logic            GOJAM,
  input  logic            INKL,
  input  logic [N_CH-1:0] REQ_UP,
  input  logic [N_CH-1:0] REQ_DN,
  output logic            CNT_CYC,
  output logic [CH_W-1:0] CNT_CH,
  output logic            PINC,
  output logic            MINC,
  output logic            GRANT_STB,
  output logic [N_CH-1:0] PEND,
  output logic            LOST
);

  typedef enum logic {IDLE = 1'b0, CNT = 1'b1} state_t;

  state_t          state, state_nx;
  logic [N_CH-1:0] prev_up, prev_dn;
  logic [N_CH-1:0] up_ev, dn_ev;
  logic [N_CH-1:0] dir, dir_nx;        // 1 = down
  logic [N_CH-1:0] pend_nx, pend_left, grant_vec;
  logic [3:0]      burst;
  logic [CH_W-1:0] winner;
  logic            win_dn;
  logic            any_pend;
  logic            grant;
  logic            lost_nx;

  assign up_ev    = REQ_UP & ~prev_up;
  assign dn_ev    = REQ_DN & ~prev_dn;
  assign any_pend = |PEND;

  // Lowest-numbered pending channel wins; scanning downward leaves the lowest.
  always_comb begin
    winner = '0;
    win_dn = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (PEND[i]) begin
        winner = CH_W'(i);
        win_dn = dir[i];
      end
    end
  end

  assign grant = T12_STB && !GOJAM && !INKL && any_pend &&
                 ((state == IDLE) || (burst < 4'(MAX_BURST)));

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      grant_vec[i] = grant && (winner == CH_W'(i));
    end
  end

  assign pend_left = PEND & ~grant_vec;

  // A lone event on a channel either arms it, cancels an opposite request, or is lost.
  always_comb begin
    pend_nx = pend_left;
    dir_nx  = dir;
    lost_nx = LOST;
    for (int i = 0; i < N_CH; i++) begin
      if (up_ev[i] ^ dn_ev[i]) begin
        if (!pend_left[i]) begin
          pend_nx[i] = 1'b1;
          dir_nx[i]  = dn_ev[i];
        end else if (dir[i] == dn_ev[i]) begin
          lost_nx = 1'b1;
        end else begin
          pend_nx[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (GOJAM) begin
      state_nx = IDLE;
    end else if (T12_STB) begin
      state_nx = grant ? CNT : IDLE;
    end
  end

  always_comb begin
    CNT_CYC = (state == CNT);
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      prev_up   <= '0;
      prev_dn   <= '0;
      PEND      <= '0;
      dir       <= '0;
      LOST      <= 1'b0;
      burst     <= '0;
      CNT_CH    <= '0;
      PINC      <= 1'b0;
      MINC      <= 1'b0;
      GRANT_STB <= 1'b0;
    end else begin
      prev_up <= REQ_UP;
      prev_dn <= REQ_DN;
      if (GOJAM) begin
        PEND      <= '0;
        dir       <= '0;
        LOST      <= 1'b0;
        burst     <= '0;
        PINC      <= 1'b0;
        MINC      <= 1'b0;
        GRANT_STB <= 1'b0;
      end else begin
        PEND      <= pend_nx;
        dir       <= dir_nx;
        LOST      <= lost_nx;
        GRANT_STB <= grant;
        if (grant) begin
          CNT_CH <= winner;
          PINC   <= !win_dn;
          MINC   <= win_dn;
          burst  <= burst + 4'd1;
        end else if (T12_STB) begin
          PINC  <= 1'b0;
          MINC  <= 1'b0;
          burst <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnt_cycle_sched.sv
// tb/tb_cnt_cycle_sched.sv - directed bench with a cycle-level reference model
module tb_cnt_cycle_sched;

  localparam int N  = 20;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          t12, gojam, inkl;
  logic [N-1:0]  req_up, req_dn;
  logic          cnt_cyc, pinc, minc, grant_stb, lost;
  logic [4:0]    cnt_ch;
  logic [N-1:0]  pend;

  int total = 0;
  int bad   = 0;

  cnt_cycle_sched #(.N_CH(N), .CH_W(5), .MAX_BURST(MB)) dut (
    .SIM_CLK(clk), .SIM_RST(rst_n), .T12_STB(t12), .GOJAM(gojam), .INKL(inkl),
    .REQ_UP(req_up), .REQ_DN(req_dn), .CNT_CYC(cnt_cyc), .CNT_CH(cnt_ch),
    .PINC(pinc), .MINC(minc), .GRANT_STB(grant_stb), .PEND(pend), .LOST(lost)
  );

  always #5 clk = ~clk;

  // Reference model: a list of pending requests, served lowest-first.
  bit m_pend [N];
  bit m_isdn [N];
  bit m_pu   [N];
  bit m_pd   [N];
  bit m_lost, m_cnt, m_pinc, m_minc, m_gs;
  int m_burst, m_ch;

  always @(posedge clk or negedge rst_n) begin
    int  win;
    bit  eu, ed;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_isdn[i] = 0; m_pu[i] = 0; m_pd[i] = 0;
      end
      m_lost = 0; m_cnt = 0; m_pinc = 0; m_minc = 0; m_gs = 0;
      m_burst = 0; m_ch = 0;
    end else begin
      win = -1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i]) win = i;
      m_gs = 0;
      if (gojam) begin
        for (int i = 0; i < N; i++) m_pend[i] = 0;
        m_lost = 0; m_cnt = 0; m_pinc = 0; m_minc = 0; m_burst = 0;
      end else begin
        if (t12) begin
          if (!inkl && win >= 0 && (!m_cnt || m_burst < MB)) begin
            m_cnt = 1; m_burst = m_burst + 1; m_ch = win; m_gs = 1;
            m_pinc = !m_isdn[win]; m_minc = m_isdn[win];
            m_pend[win] = 0;
          end else begin
            m_cnt = 0; m_burst = 0; m_pinc = 0; m_minc = 0;
          end
        end
        for (int i = 0; i < N; i++) begin
          eu = req_up[i] && !m_pu[i];
          ed = req_dn[i] && !m_pd[i];
          if (eu != ed) begin
            if (!m_pend[i]) begin
              m_pend[i] = 1; m_isdn[i] = ed;
            end else if (m_isdn[i] == ed) begin
              m_lost = 1;
            end else begin
              m_pend[i] = 0;
            end
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        m_pu[i] = req_up[i]; m_pd[i] = req_dn[i];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] mp;
    for (int i = 0; i < N; i++) mp[i] = m_pend[i];
    chk("m_cnt_cyc", 32'(cnt_cyc), 32'(m_cnt));
    chk("m_cnt_ch", 32'(cnt_ch), 32'(m_ch));
    chk("m_pinc", 32'(pinc), 32'(m_pinc));
    chk("m_minc", 32'(minc), 32'(m_minc));
    chk("m_grant_stb", 32'(grant_stb), 32'(m_gs));
    chk("m_pend", 32'(pend), 32'(mp));
    chk("m_lost", 32'(lost), 32'(m_lost));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] u, input logic [N-1:0] d);
    req_up = u; req_dn = d;
    step();
    req_up = '0; req_dn = '0;
    step();
  endtask

  task automatic strobe();
    t12 = 1'b1;
    step();
    t12 = 1'b0;
  endtask

  task automatic do_gojam();
    gojam = 1'b1;
    step();
    gojam = 1'b0;
  endtask

  int exp_ch [7] = '{2, 7, 9, 12, -1, 15, -1};

  initial begin
    rst_n = 1'b0; t12 = 0; gojam = 0; inkl = 0;
    req_up = '0; req_dn = '0;
    req_up[3] = 1'b1;
    repeat (3) step();
    chk("rst_pend", 32'(pend), 32'h0);
    chk("rst_lost", 32'(lost), 32'h0);
    chk("rst_cnt_cyc", 32'(cnt_cyc), 32'h0);
    rst_n = 1'b1;
    step();
    chk("post_rst_pend3", 32'(pend), 32'h8);
    step();
    chk("held_level_no_refire", 32'(pend), 32'h8);
    req_up = '0;
    do_gojam();
    chk("gojam_clear", 32'(pend), 32'h0);

    // single up request on channel 5
    pulse(20'h00020, 20'h0);
    strobe();
    chk("up5_cnt_cyc", 32'(cnt_cyc), 32'h1);
    chk("up5_cnt_ch", 32'(cnt_ch), 32'd5);
    chk("up5_pinc", 32'(pinc), 32'h1);
    chk("up5_grant", 32'(grant_stb), 32'h1);
    chk("up5_pend", 32'(pend), 32'h0);
    step();
    chk("up5_grant_one_cycle", 32'(grant_stb), 32'h0);
    strobe();
    chk("up5_release", 32'(cnt_cyc), 32'h0);
    step();

    // priority and burst limit: channels 2,7,9,12,15 down
    pulse(20'h0, 20'h09284);
    for (int k = 0; k < 7; k++) begin
      strobe();
      if (exp_ch[k] >= 0) begin
        chk("burst_cnt_cyc", 32'(cnt_cyc), 32'h1);
        chk("burst_ch", 32'(cnt_ch), 32'(exp_ch[k]));
        chk("burst_minc", 32'(minc), 32'h1);
      end else begin
        chk("burst_forced_idle", 32'(cnt_cyc), 32'h0);
      end
      step();
    end

    // cancel on channel 4, lost on channel 8
    pulse(20'h00010, 20'h0);
    pulse(20'h0, 20'h00010);
    chk("cancel_pend", 32'(pend), 32'h0);
    chk("cancel_lost", 32'(lost), 32'h0);
    pulse(20'h00100, 20'h0);
    pulse(20'h00100, 20'h0);
    chk("lost_pend", 32'(pend), 32'h100);
    chk("lost_flag", 32'(lost), 32'h1);
    do_gojam();
    chk("lost_cleared", 32'(lost), 32'h0);

    // inhibit, then a request racing the strobe
    pulse(20'h00002, 20'h0);
    inkl = 1'b1;
    strobe();
    inkl = 1'b0;
    chk("inkl_idle", 32'(cnt_cyc), 32'h0);
    chk("inkl_pend", 32'(pend), 32'h2);
    req_up = 20'h00001; t12 = 1'b1;
    step();
    req_up = '0; t12 = 1'b0;
    chk("race_ch1", 32'(cnt_ch), 32'd1);
    chk("race_pend0", 32'(pend), 32'h1);
    step();
    strobe();
    chk("race_ch0", 32'(cnt_ch), 32'd0);
    strobe();
    chk("race_done", 32'(cnt_cyc), 32'h0);

    // event on the channel being granted re-arms it
    pulse(20'h04000, 20'h0);
    req_dn = 20'h04000; t12 = 1'b1;
    step();
    req_dn = '0; t12 = 1'b0;
    chk("regrant_pinc", 32'(pinc), 32'h1);
    chk("regrant_pend", 32'(pend), 32'h4000);
    strobe();
    chk("regrant_minc", 32'(minc), 32'h1);
    chk("regrant_ch", 32'(cnt_ch), 32'd14);
    strobe();

    // simultaneous up and down edges cancel out
    pulse(20'h20000, 20'h20000);
    chk("both_edges", 32'(pend), 32'h0);

    // GOJAM in the middle of a burst
    pulse(20'h02C08, 20'h0);
    pulse(20'h00400, 20'h0);
    strobe();
    chk("gj_first_ch", 32'(cnt_ch), 32'd3);
    chk("gj_lost_set", 32'(lost), 32'h1);
    gojam = 1'b1; t12 = 1'b1; req_up = 20'h00040;
    step();
    gojam = 1'b0; t12 = 1'b0;
    chk("gj_cnt_cyc", 32'(cnt_cyc), 32'h0);
    chk("gj_pend", 32'(pend), 32'h0);
    chk("gj_lost", 32'(lost), 32'h0);
    chk("gj_no_grant", 32'(grant_stb), 32'h0);
    step();
    chk("gj_level_no_refire", 32'(pend), 32'h0);
    req_up = '0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
